// File: rtl/amp_autorange_pkg.sv
// Shared types and constants for the dual-channel amplifier autorange block.
// Gain codes 0..6 select x1, x2, x5, x10, x20, x50 and x100.
package amp_autorange_pkg;

   localparam int                CODE_W   = 4;
   localparam logic [CODE_W-1:0] MAX_CODE = 4'd6;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      DECIDE  = 2'd3
   } state_t;

   function automatic logic [CODE_W-1:0] clamp_code(input logic [CODE_W-1:0] code);
      return (code > MAX_CODE) ? MAX_CODE : code;
   endfunction

endpackage

// File: rtl/amp_peak_det.sv
// Running peak-magnitude detector for one signed ADC channel.
// The most negative sample saturates to the largest positive magnitude.
module amp_peak_det #(
   parameter int ADC_W = 14
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    clr,
   input  logic                    vld,
   input  logic signed [ADC_W-1:0] sample,
   output logic        [ADC_W-1:0] peak
);

   localparam logic [ADC_W-1:0] S_MIN   = {1'b1, {(ADC_W-1){1'b0}}};
   localparam logic [ADC_W-1:0] MAG_MAX = {1'b0, {(ADC_W-1){1'b1}}};

   logic [ADC_W-1:0] mag;

   always_comb begin
      mag = sample;
      if (sample[ADC_W-1]) begin
         mag = (sample == S_MIN) ? MAG_MAX : -sample;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         peak <= '0;
      end else if (clr) begin
         peak <= '0;
      end else if (vld && (mag > peak)) begin
         peak <= mag;
      end
   end

endmodule

// File: rtl/amp_autorange.sv
// Autorange controller: settle, measure a window of peaks, then step each
// channel's gain code one notch toward the band [LO_TH, HI_TH).
module amp_autorange
   import amp_autorange_pkg::*;
#(
   parameter int ADC_W      = 14,
   parameter int WIN_LEN    = 1024,
   parameter int SETTLE_CYC = 2000,
   parameter int HI_TH      = 7000,
   parameter int LO_TH      = 2600
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_en,
   input  logic                    i_manual,
   input  logic [CODE_W-1:0]       i_man_a,
   input  logic [CODE_W-1:0]       i_man_b,
   input  logic signed [ADC_W-1:0] i_adc_a,
   input  logic signed [ADC_W-1:0] i_adc_b,
   input  logic                    i_adc_vld,
   output logic [CODE_W-1:0]       o_amp_a,
   output logic [CODE_W-1:0]       o_amp_b,
   output logic                    o_locked,
   output logic                    o_ovr_a,
   output logic                    o_ovr_b,
   output state_t                  o_state
);

   localparam int WIN_W = $clog2(WIN_LEN + 1);
   localparam int ST_W  = $clog2(SETTLE_CYC + 1);

   localparam logic [ADC_W-1:0] HI_V      = ADC_W'(HI_TH);
   localparam logic [ADC_W-1:0] LO_V      = ADC_W'(LO_TH);
   localparam logic [WIN_W-1:0] WIN_LAST  = WIN_W'(WIN_LEN - 1);
   localparam logic [ST_W-1:0]  SETL_LAST = ST_W'(SETTLE_CYC - 1);

   state_t            state;
   logic [WIN_W-1:0]  win_cnt;
   logic [ST_W-1:0]   settle_cnt;
   logic [ADC_W-1:0]  peak_a;
   logic [ADC_W-1:0]  peak_b;
   logic              peak_clr;
   logic              peak_vld;
   logic              hi_a, hi_b, lo_a, lo_b;
   logic [CODE_W-1:0] nxt_a, nxt_b;

   function automatic logic [CODE_W-1:0] step_code(input logic [CODE_W-1:0] code,
                                                   input logic hi, input logic lo);
      if (hi && (code != '0))          return code - 1'b1;
      else if (lo && (code < MAX_CODE)) return code + 1'b1;
      return code;
   endfunction

   // Peaks are held clear outside MEASURE, so every window starts from zero.
   assign peak_clr = (state != MEASURE);
   assign peak_vld = i_adc_vld && (state == MEASURE);

   amp_peak_det #(.ADC_W(ADC_W)) u_peak_a (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .clr     (peak_clr),
      .vld     (peak_vld),
      .sample  (i_adc_a),
      .peak    (peak_a)
   );

   amp_peak_det #(.ADC_W(ADC_W)) u_peak_b (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .clr     (peak_clr),
      .vld     (peak_vld),
      .sample  (i_adc_b),
      .peak    (peak_b)
   );

   assign hi_a  = (peak_a >= HI_V);
   assign hi_b  = (peak_b >= HI_V);
   assign lo_a  = (peak_a <  LO_V);
   assign lo_b  = (peak_b <  LO_V);
   assign nxt_a = step_code(o_amp_a, hi_a, lo_a);
   assign nxt_b = step_code(o_amp_b, hi_b, lo_b);

   assign o_state = state;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state      <= IDLE;
         win_cnt    <= '0;
         settle_cnt <= '0;
         o_amp_a    <= '0;
         o_amp_b    <= '0;
         o_locked   <= 1'b0;
         o_ovr_a    <= 1'b0;
         o_ovr_b    <= 1'b0;
      end else if (i_manual) begin
         state      <= IDLE;
         win_cnt    <= '0;
         settle_cnt <= '0;
         o_locked   <= 1'b0;
         o_amp_a    <= clamp_code(i_man_a);
         o_amp_b    <= clamp_code(i_man_b);
      end else if (!i_en) begin
         state      <= IDLE;
         win_cnt    <= '0;
         settle_cnt <= '0;
         o_locked   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               state      <= SETTLE;
               settle_cnt <= '0;
            end
            SETTLE: begin
               if (settle_cnt == SETL_LAST) begin
                  state      <= MEASURE;
                  settle_cnt <= '0;
                  win_cnt    <= '0;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            MEASURE: begin
               if (i_adc_vld) begin
                  if (win_cnt == WIN_LAST) begin
                     state   <= DECIDE;
                     win_cnt <= '0;
                  end else begin
                     win_cnt <= win_cnt + 1'b1;
                  end
               end
            end
            DECIDE: begin
               o_amp_a <= nxt_a;
               o_amp_b <= nxt_b;
               o_ovr_a <= hi_a && (o_amp_a == '0);
               o_ovr_b <= hi_b && (o_amp_b == '0);
               if ((nxt_a != o_amp_a) || (nxt_b != o_amp_b)) begin
                  state      <= SETTLE;
                  settle_cnt <= '0;
                  o_locked   <= 1'b0;
               end else begin
                  state    <= MEASURE;
                  o_locked <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/amp_autorange.md
AMP_AUTORANGE -- requirements
Module: amp_autorange

Interface
REQ-001 Parameter ADC_W, 14, signed ADC sample width.
REQ-002 Parameter WIN_LEN, 1024, valid samples per measurement window.
REQ-003 Parameter SETTLE_CYC, 2000, i_clk cycles waited after any gain change.
REQ-004 Parameter HI_TH, 7000, peak magnitude at or above which gain steps down.
REQ-005 Parameter LO_TH, 2600, peak magnitude below which gain steps up; LO_TH*2.5 < HI_TH SHALL hold.
REQ-006 i_clk  in  1  clock; all logic on rising edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 i_en  in  1  autorange enable.
REQ-009 i_manual  in  1  1 = gain codes taken from i_man_a/i_man_b.
REQ-010 i_man_a, i_man_b  in  4 each  manual gain codes.
REQ-011 i_adc_a, i_adc_b  in  ADC_W each, signed  channel A/B samples.
REQ-012 i_adc_vld  in  1  one-cycle qualifier for both samples.
REQ-013 o_amp_a, o_amp_b  out  4 each  gain codes 0..6 (x1,x2,x5,x10,x20,x50,x100) for the shift-register gain driver.
REQ-014 o_locked  out  1  both channels in range after the last window.
REQ-015 o_ovr_a, o_ovr_b  out  1 each  channel peak >= HI_TH while code = 0.

Function
REQ-016 The block SHALL use FSM states IDLE, SETTLE, MEASURE, DECIDE.
REQ-017 IDLE -> SETTLE when i_en=1 and i_manual=0; otherwise IDLE is held.
REQ-018 SETTLE SHALL count SETTLE_CYC clock cycles, then enter MEASURE with both peak registers cleared to 0 and sample counter cleared.
REQ-019 MEASURE SHALL, per i_adc_vld, update peak_x = max(peak_x, |i_adc_x|); |-2^(ADC_W-1)| saturates to 2^(ADC_W-1)-1.
REQ-020 MEASURE -> DECIDE on the cycle the WIN_LEN-th valid sample is absorbed; samples without i_adc_vld are ignored.
REQ-021 DECIDE (one cycle) per channel, independently: peak >= HI_TH and code > 0 -> code-1; peak < LO_TH and code < 6 -> code+1; else hold.
REQ-022 New codes SHALL appear on o_amp_x the cycle after DECIDE.
REQ-023 DECIDE -> SETTLE if either code changed, o_locked <= 0; else -> MEASURE (fresh window), o_locked <= 1.
REQ-024 o_ovr_x SHALL be updated only in DECIDE: 1 if peak_x >= HI_TH and code_x = 0, else 0.
REQ-025 Peak at code 6 below LO_TH SHALL hold code 6; it does not block lock.
REQ-026 i_en=0 in any state SHALL return FSM to IDLE next cycle, hold codes, clear o_locked; o_ovr_x held.
REQ-027 i_manual=1 SHALL force IDLE, o_locked=0, and register o_amp_x <= min(i_man_x, 6) every cycle.
REQ-028 On i_manual 1->0 with i_en=1 the block SHALL resume from the current codes via SETTLE.
REQ-029 i_manual takes priority over i_en.

Reset
REQ-030 Reset SHALL set state IDLE, o_amp_a = o_amp_b = 0, o_locked = 0, o_ovr_a = o_ovr_b = 0, peaks and counters 0.
REQ-031 Reset asserted mid-window SHALL discard the window; no partial decision is made.

Structure
REQ-032 Package amp_autorange_pkg SHALL hold the state enum, MAX_CODE = 6 and code width 4.
REQ-033 Sub-module amp_peak_det (abs, saturate, running max, synchronous clear) SHALL be instantiated once per channel.
REQ-034 Window counter SHALL be wide enough for WIN_LEN; settle counter wide enough for SETTLE_CYC.

Verification (SETTLE_CYC=20, WIN_LEN=16 for sim)
REQ-035 Reset release, i_en=1, both inputs amplitude 8000 -> codes stay 0, o_ovr_a = o_ovr_b = 1 after first DECIDE, o_locked = 1.
REQ-036 Both inputs amplitude 100 at all gains -> codes step 0->1->...->6, one step per window, each step followed by 20-cycle SETTLE; o_locked = 1 at code 6.
REQ-037 Channel A peak 7500, channel B peak 1000, both codes 3 -> after DECIDE A = 2, B = 4 in the same cycle; o_locked = 0.
REQ-038 Sample -8192 on A with code 2 -> peak 8191, A steps to 1.
REQ-039 i_manual=1, i_man_a = 9, i_man_b = 4 -> o_amp_a = 6, o_amp_b = 4 next cycle; release i_manual -> SETTLE, then tracking from 6/4.
REQ-040 Reset asserted at sample 10 of a window -> all outputs 0, no code change; i_en drop mid-MEASURE -> IDLE, codes unchanged.
